// File: rtl/seg14_scroll_mux.sv
// seg14_scroll_mux: scans NUM_DIGITS 14-segment digits from a writable char buffer with dwell, blanking, frame strobe and optional scrolling
// Ports: clk/rst_n (async active-low); dwell, msg_len, scroll_en, scroll_frames, blank configure the scan;
//        wr_en/wr_addr/wr_data write the char buffer; sel/segm drive the pads; frame_tick pulses on the last cycle of a frame.
module seg14_scroll_mux #(
  parameter int NUM_DIGITS = 12,
  parameter int SEG_W      = 14,
  parameter int MSG_LEN    = 16,
  parameter int DWELL_W    = 16,
  parameter int AW         = $clog2(MSG_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic [AW:0]           msg_len,
  input  logic                  scroll_en,
  input  logic [7:0]            scroll_frames,
  input  logic                  blank,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [5:0]            wr_data,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [SEG_W-1:0]      segm,
  output logic                  frame_tick
);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [13:0] FONT [36] = '{
    14'b11101111000000, 14'b11110001010010, 14'b10011100000000, 14'b11110000010010,
    14'b10011110000000, 14'b10001110000000, 14'b10111101000000, 14'b01101111000000,
    14'b10010000010010, 14'b01111000000000, 14'b00001110001100, 14'b00011100000000,
    14'b01101100101000, 14'b01101100100100, 14'b11111100000000, 14'b11001111000000,
    14'b11111100000100, 14'b11001111000100, 14'b10110111000000, 14'b10000000010010,
    14'b01111100000000, 14'b00001100001001, 14'b01101100000101, 14'b00000000101101,
    14'b00000000101010, 14'b10010000001001, 14'b11111100001001, 14'b01100000001000,
    14'b11011011000000, 14'b11110001000000, 14'b01100111000000, 14'b10110111000000,
    14'b10111111000000, 14'b11100000000000, 14'b11111111000000, 14'b11110111000000
  };
  logic [5:0]         mem [MSG_LEN];
  logic [DW-1:0]      d;
  logic [DWELL_W-1:0] c;
  logic [AW-1:0]      p, o, cur, p_nx, o_base, o_step, idx;
  logic [7:0]         fc;
  logic [AW:0]        len, new_len;
  logic               adv, fend;
  logic [5:0]         code;
  logic [13:0]        glyph;
  // at digit 0 the pointer restarts from the scroll offset, otherwise it follows p
  always_comb begin
    adv     = c >= dwell;
    fend    = adv && d == DW'(NUM_DIGITS - 1);
    cur     = (d == '0) ? o : p;
    p_nx    = ({1'b0, cur} + 1'b1 == len) ? '0 : cur + 1'b1;
    new_len = (msg_len == '0) ? (AW+1)'(1) : (msg_len > (AW+1)'(MSG_LEN)) ? (AW+1)'(MSG_LEN) : msg_len;
    o_base  = ({1'b0, o} >= new_len) ? '0 : o;
    o_step  = ({1'b0, o_base} + 1'b1 == new_len) ? '0 : o_base + 1'b1;
    idx     = scroll_en ? cur : AW'(d);
    code    = (scroll_en || int'(d) < int'(len)) ? mem[idx] : 6'd63;
    glyph   = (code < 6'd36) ? FONT[code] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      segm       <= '0;
      frame_tick <= 1'b0;
      d          <= '0;
      c          <= '0;
      p          <= '0;
      o          <= '0;
      fc         <= '0;
      len        <= (AW+1)'(1);
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= 6'd63;
    end else begin
      sel        <= NUM_DIGITS'(1) << d;
      segm       <= blank ? '0 : SEG_W'(glyph);
      frame_tick <= fend;
      if (wr_en) mem[wr_addr] <= wr_data;
      if (adv) begin
        c <= '0;
        d <= fend ? '0 : d + 1'b1;
        p <= p_nx;
      end else c <= c + 1'b1;
      if (fend) len <= new_len;
      if (!scroll_en) begin
        o  <= '0;
        fc <= '0;
      end else if (fend) begin
        fc <= (fc == scroll_frames) ? '0 : fc + 1'b1;
        o  <= (fc == scroll_frames) ? o_step : o_base;
      end
    end
  end
endmodule
